// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle RV32I controller.
// Opcodes, 4-bit state encodings and datapath select codes.
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_ALUWB  = 4'd7,
      S_EXECI  = 4'd8,
      S_JAL    = 4'd9,
      S_BEQ    = 4'd10,
      S_TRAP   = 4'd11,
      S_JALR   = 4'd12,
      S_LUI    = 4'd13,
      S_JAL2   = 4'd14
   } state_t;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REGA  = 2'b10;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   // States that hold a memory request open and are subject to the wait timeout.
   function automatic logic is_mem_wait(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Maps the IR opcode to the state that follows DECODE.
// Jump-class opcodes are treated as illegal when SUPPORT_JUMP is 0.
module mc_opcode_decode
   import ctrl_pkg::*;
#(
   parameter int SUPPORT_JUMP = 1
) (
   input  logic [6:0] opcode,
   output logic [3:0] decode_next
);

   always_comb begin
      decode_next = S_TRAP;
      case (opcode)
         OP_LOAD,
         OP_STORE:  decode_next = S_MEMADR;
         OP_R:      decode_next = S_EXECR;
         OP_I:      decode_next = S_EXECI;
         OP_BRANCH: decode_next = S_BEQ;
         OP_JAL:    decode_next = (SUPPORT_JUMP != 0) ? S_JAL  : S_TRAP;
         OP_JALR:   decode_next = (SUPPORT_JUMP != 0) ? S_JALR : S_TRAP;
         OP_LUI:    decode_next = (SUPPORT_JUMP != 0) ? S_LUI  : S_TRAP;
         default:   decode_next = S_TRAP;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute/writeback
// over a shared ALU and unified memory, with a memory wait timeout and sticky trap.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int SUPPORT_JUMP = 1,
   parameter int MEM_TIMEOUT  = 15,
   parameter int TO_W         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       trap,
   output logic [3:0] state_o
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

   state_t          state;
   state_t          state_next;
   logic [3:0]      decode_next;
   logic [TO_W-1:0] wait_cnt;
   logic            timed_out;
   logic            mem_req_raw;
   logic            mem_we_raw;
   logic            ir_write_raw;
   logic            pc_write_raw;
   logic            reg_write_raw;

   mc_opcode_decode #(
      .SUPPORT_JUMP(SUPPORT_JUMP)
   ) u_decode (
      .opcode      (opcode),
      .decode_next (decode_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Any state change restarts the count, so each memory state starts its wait at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state_next != state) begin
         wait_cnt <= '0;
      end else if (is_mem_wait(state) && !mem_ready) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LIMIT) && !mem_ready;

   always_comb begin
      state_next = S_TRAP;
      case (state)
         S_FETCH:  state_next = mem_ready ? S_DECODE : (timed_out ? S_TRAP : S_FETCH);
         S_DECODE: state_next = state_t'(decode_next);
         S_MEMADR: state_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_next = mem_ready ? S_MEMWB : (timed_out ? S_TRAP : S_MEMRD);
         S_MEMWB:  state_next = S_FETCH;
         S_MEMWR:  state_next = mem_ready ? S_FETCH : (timed_out ? S_TRAP : S_MEMWR);
         S_EXECR:  state_next = S_ALUWB;
         S_EXECI:  state_next = S_ALUWB;
         S_ALUWB:  state_next = S_FETCH;
         S_BEQ:    state_next = S_FETCH;
         S_JAL:    state_next = S_ALUWB;
         S_JALR:   state_next = S_JAL2;
         S_JAL2:   state_next = S_ALUWB;
         S_LUI:    state_next = S_FETCH;
         S_TRAP:   state_next = S_TRAP;
         default:  state_next = S_TRAP;
      endcase
   end

   always_comb begin
      mem_req_raw   = 1'b0;
      mem_we_raw    = 1'b0;
      ir_write_raw  = 1'b0;
      pc_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      adr_src       = 1'b0;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_REGB;
      alu_op        = ALUOP_ADD;
      result_src    = RES_ALUOUT;
      case (state)
         S_FETCH: begin
            mem_req_raw  = 1'b1;
            ir_write_raw = mem_ready;
            pc_write_raw = mem_ready;
            alu_src_b    = SRCB_FOUR;
            result_src   = RES_ALU;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_REGA;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_req_raw = 1'b1;
            adr_src     = 1'b1;
         end
         S_MEMWB: begin
            result_src    = RES_MEM;
            reg_write_raw = 1'b1;
         end
         S_MEMWR: begin
            mem_req_raw = 1'b1;
            mem_we_raw  = 1'b1;
            adr_src     = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_REGA;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_REGA;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
         end
         S_BEQ: begin
            alu_src_a    = SRCA_REGA;
            alu_op       = ALUOP_SUB;
            pc_write_raw = zero;
         end
         // ALUOut still holds the DECODE target; the ALU forms the link address meanwhile.
         S_JAL: begin
            alu_src_a    = SRCA_OLDPC;
            alu_src_b    = SRCB_FOUR;
            pc_write_raw = 1'b1;
         end
         S_JALR: begin
            alu_src_a    = SRCA_REGA;
            alu_src_b    = SRCB_IMM;
            result_src   = RES_ALU;
            pc_write_raw = 1'b1;
         end
         S_JAL2: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
         end
         S_LUI: begin
            result_src    = RES_IMM;
            reg_write_raw = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign mem_req   = mem_req_raw   && !rst;
   assign mem_we    = mem_we_raw    && !rst;
   assign ir_write  = ir_write_raw  && !rst;
   assign pc_write  = pc_write_raw  && !rst;
   assign reg_write = reg_write_raw && !rst;
   assign trap      = (state == S_TRAP);
   assign state_o   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors push expected
// state/strobes into a queue that a negedge monitor pops and compares.
module tb_multicycle_control;

   typedef struct packed {
      logic [3:0] st;
      logic [5:0] strobes;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       adr_src;
   logic       ir_write;
   logic       pc_write;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] result_src;
   logic       trap;
   logic [3:0] state_o;

   exp_t scoreboard[$];
   int   testsRun;
   int   testsFailed;
   int   cycleNo;
   bit   stimDone;

   localparam logic [6:0] ADD  = 7'b0110011;
   localparam logic [6:0] ADDI = 7'b0010011;
   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] BEQ  = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] LUI  = 7'b0110111;
   localparam logic [6:0] BAD  = 7'b1111111;

   // Strobe vector order: mem_req, mem_we, ir_write, pc_write, reg_write, trap.
   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] FTCH = 6'b101100;
   localparam logic [5:0] MREQ = 6'b100000;
   localparam logic [5:0] MWR  = 6'b110000;
   localparam logic [5:0] PCW  = 6'b000100;
   localparam logic [5:0] REGW = 6'b000010;
   localparam logic [5:0] TRP  = 6'b000001;

   multicycle_control #(
      .SUPPORT_JUMP(1),
      .MEM_TIMEOUT (15),
      .TO_W        (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .adr_src    (adr_src),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .result_src (result_src),
      .trap       (trap),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Selects per state as {adr_src, alu_src_a, alu_src_b, alu_op, result_src}, written from the state table.
   function automatic logic [8:0] selTable(input logic [3:0] st);
      case (st)
         4'd0:    return 9'b0_00_10_00_10;
         4'd1:    return 9'b0_01_01_00_00;
         4'd2:    return 9'b0_10_01_00_00;
         4'd3:    return 9'b1_00_00_00_00;
         4'd4:    return 9'b0_00_00_00_01;
         4'd5:    return 9'b1_00_00_00_00;
         4'd6:    return 9'b0_10_00_10_00;
         4'd8:    return 9'b0_10_01_10_00;
         4'd9:    return 9'b0_01_10_00_00;
         4'd10:   return 9'b0_10_00_01_00;
         4'd12:   return 9'b0_10_01_00_10;
         4'd13:   return 9'b0_00_00_00_11;
         4'd14:   return 9'b0_01_10_00_00;
         default: return 9'b0_00_00_00_00;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [8:0] got, input logic [8:0] want);
      testsRun++;
      if (got !== want) begin
         testsFailed++;
         $display("[TB] FAIL cycle %0d %s: got %b want %b", cycleNo, name, got, want);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [6:0] op, input logic z,
                                input logic mr, input logic [3:0] st, input logic [5:0] sb);
      exp_t e;
      rst       = r;
      opcode    = op;
      zero      = z;
      mem_ready = mr;
      e.st      = st;
      e.strobes = sb;
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (scoreboard.size() > 0) begin
         e = scoreboard.pop_front();
         checkOutput("state", {5'd0, state_o}, {5'd0, e.st});
         checkOutput("strobes", {3'd0, mem_req, mem_we, ir_write, pc_write, reg_write, trap},
                     {3'd0, e.strobes});
         checkOutput("selects", {adr_src, alu_src_a, alu_src_b, alu_op, result_src}, selTable(e.st));
         cycleNo++;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      cycleNo     = 0;
      stimDone    = 1'b0;
      rst         = 1'b1;
      opcode      = ADD;
      zero        = 1'b0;
      mem_ready   = 1'b0;
      @(posedge clk);
      #1;

      applyStimulus(1, ADD, 0, 1, 4'd0, NONE);

      // add with mem_ready always high
      applyStimulus(0, ADD, 0, 1, 4'd0, FTCH);
      applyStimulus(0, ADD, 0, 1, 4'd1, NONE);
      applyStimulus(0, ADD, 0, 1, 4'd6, NONE);
      applyStimulus(0, ADD, 0, 1, 4'd7, REGW);

      // lw with three wait cycles in MEMRD
      applyStimulus(0, LW, 0, 1, 4'd0, FTCH);
      applyStimulus(0, LW, 0, 1, 4'd1, NONE);
      applyStimulus(0, LW, 0, 1, 4'd2, NONE);
      for (int i = 0; i < 3; i++) applyStimulus(0, LW, 0, 0, 4'd3, MREQ);
      applyStimulus(0, LW, 0, 1, 4'd3, MREQ);
      applyStimulus(0, LW, 0, 1, 4'd4, REGW);

      // sw
      applyStimulus(0, SW, 0, 1, 4'd0, FTCH);
      applyStimulus(0, SW, 0, 1, 4'd1, NONE);
      applyStimulus(0, SW, 0, 1, 4'd2, NONE);
      applyStimulus(0, SW, 0, 1, 4'd5, MWR);

      // beq taken then not taken
      applyStimulus(0, BEQ, 1, 1, 4'd0, FTCH);
      applyStimulus(0, BEQ, 1, 1, 4'd1, NONE);
      applyStimulus(0, BEQ, 1, 1, 4'd10, PCW);
      applyStimulus(0, BEQ, 0, 1, 4'd0, FTCH);
      applyStimulus(0, BEQ, 0, 1, 4'd1, NONE);
      applyStimulus(0, BEQ, 0, 1, 4'd10, NONE);

      // jal, jalr, lui, addi
      applyStimulus(0, JAL, 0, 1, 4'd0, FTCH);
      applyStimulus(0, JAL, 0, 1, 4'd1, NONE);
      applyStimulus(0, JAL, 0, 1, 4'd9, PCW);
      applyStimulus(0, JAL, 0, 1, 4'd7, REGW);
      applyStimulus(0, JALR, 0, 1, 4'd0, FTCH);
      applyStimulus(0, JALR, 0, 1, 4'd1, NONE);
      applyStimulus(0, JALR, 0, 1, 4'd12, PCW);
      applyStimulus(0, JALR, 0, 1, 4'd14, NONE);
      applyStimulus(0, JALR, 0, 1, 4'd7, REGW);
      applyStimulus(0, LUI, 0, 1, 4'd0, FTCH);
      applyStimulus(0, LUI, 0, 1, 4'd1, NONE);
      applyStimulus(0, LUI, 0, 1, 4'd13, REGW);

      // mem_ready arriving exactly when the wait count reaches the limit completes normally
      for (int i = 0; i < 15; i++) applyStimulus(0, ADDI, 0, 0, 4'd0, MREQ);
      applyStimulus(0, ADDI, 0, 1, 4'd0, FTCH);
      applyStimulus(0, ADDI, 0, 1, 4'd1, NONE);
      applyStimulus(0, ADDI, 0, 1, 4'd8, NONE);
      applyStimulus(0, ADDI, 0, 1, 4'd7, REGW);

      // reset during MEMWR with mem_ready high
      applyStimulus(0, SW, 0, 1, 4'd0, FTCH);
      applyStimulus(0, SW, 0, 1, 4'd1, NONE);
      applyStimulus(0, SW, 0, 1, 4'd2, NONE);
      applyStimulus(1, SW, 0, 1, 4'd5, NONE);

      // mem_ready stuck low in FETCH: trap after sixteen wait cycles
      for (int i = 0; i < 16; i++) applyStimulus(0, ADD, 0, 0, 4'd0, MREQ);
      for (int i = 0; i < 3; i++) applyStimulus(0, ADD, 0, 1, 4'd11, TRP);
      applyStimulus(1, ADD, 0, 1, 4'd11, TRP);

      // illegal opcode
      applyStimulus(0, BAD, 0, 1, 4'd0, FTCH);
      applyStimulus(0, BAD, 0, 1, 4'd1, NONE);
      applyStimulus(0, BAD, 0, 1, 4'd11, TRP);
      applyStimulus(0, BAD, 1, 1, 4'd11, TRP);
      applyStimulus(1, BAD, 0, 1, 4'd11, TRP);
      applyStimulus(0, ADD, 0, 0, 4'd0, MREQ);

      stimDone = 1'b1;
      @(posedge clk);
      @(posedge clk);
      testsRun++;
      if (scoreboard.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: got %0d entries left want 0", scoreboard.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
